// File: rtl/brent_kung_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Define BKA_PIPE_OVF_EN to add the pipelined signed-overflow output Ovf.
module brent_kung_adder_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef BKA_PIPE_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int LOG = $clog2(WIDTH);
    localparam int NL  = 2 * LOG - 1;  // up-sweep plus down-sweep prefix levels

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p0;
        logic             cin;
`ifdef BKA_PIPE_OVF_EN
        logic             a_msb;
        logic             bx_msb;
`endif
    } st_t;

    // Prefix levels completed before rank r is registered; spreads levels evenly.
    function automatic int cut(input int r);
        return ((r + 1) * NL) / int'(STAGES);
    endfunction

    function automatic st_t pre_proc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bx,
                                     input logic cin);
        st_t s;
        s.p0   = a ^ bx;
        s.p    = s.p0;
        s.g    = a & bx;
        s.g[0] = s.g[0] | (s.p0[0] & cin);  // fold carry-in into bit 0 generate
        s.cin  = cin;
`ifdef BKA_PIPE_OVF_EN
        s.a_msb  = a[WIDTH-1];
        s.bx_msb = bx[WIDTH-1];
`endif
        return s;
    endfunction

    function automatic st_t prefix_level(input st_t s, input int m);
        st_t  r;
        int   span;
        int   half;
        int   j;
        logic up;
        logic sel;
        r    = s;
        up   = (m < LOG);
        span = up ? (1 << (m + 1)) : (1 << (2 * LOG - 1 - m));
        half = span / 2;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sel = up ? ((i + 1) % span == 0) : ((i >= span) && ((i + 1) % span == half));
            j   = (i >= half) ? (i - half) : 0;
            if (sel) begin
                r.g[i] = s.g[i] | (s.p[i] & s.g[j]);
                r.p[i] = s.p[i] & s.p[j];
            end
        end
        return r;
    endfunction

    function automatic st_t prefix_range(input st_t s, input int lo, input int hi);
        st_t r;
        r = s;
        for (int m = 0; m < NL; m++) begin
            if (m >= lo && m < hi) begin
                r = prefix_level(r, m);
            end
        end
        return r;
    endfunction

    logic             advance;
    st_t              in_st;
    st_t              last_st;
    logic             last_vld;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;
    assign in_st    = pre_proc(A, Sub ? ~B : B, Cin);

    for (genvar r = 0; r < int'(STAGES) - 1; r++) begin : g_rank
        st_t  st_d;
        st_t  st_q;
        logic vld_d;
        logic vld_q;

        if (r == 0) begin : g_first
            assign st_d  = prefix_range(in_st, 0, cut(0));
            assign vld_d = in_valid;
        end else begin : g_next
            assign st_d  = prefix_range(g_rank[r-1].st_q, cut(r - 1), cut(r));
            assign vld_d = g_rank[r-1].vld_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q  <= '0;
                vld_q <= 1'b0;
            end else if (advance) begin
                st_q  <= st_d;
                vld_q <= vld_d;
            end
        end
    end

    if (STAGES > 1) begin : g_tail
        assign last_st  = prefix_range(g_rank[STAGES-2].st_q, cut(int'(STAGES) - 2), NL);
        assign last_vld = g_rank[STAGES-2].vld_q;
    end else begin : g_tail
        assign last_st  = prefix_range(in_st, 0, NL);
        assign last_vld = in_valid;
    end

    always_comb begin
        sum_d  = last_st.p0 ^ {last_st.g[WIDTH-2:0], last_st.cin};
        cout_d = last_st.g[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (advance) begin
            out_valid_q <= last_vld;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;

`ifdef BKA_PIPE_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = (last_st.a_msb == last_st.bx_msb) && (sum_d[WIDTH-1] != last_st.a_msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_brent_kung_adder_pipe.sv
// Scoreboard bench for brent_kung_adder_pipe: directed vectors, random stream with
// backpressure, fill/stall and mid-stream reset.
`timescale 1ns/1ps
module tb_brent_kung_adder_pipe;

    localparam int unsigned W = 32;
    localparam int unsigned S = 2;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef BKA_PIPE_OVF_EN
    logic         Ovf;
`endif

    exp_t         q[$];
    int           total    = 0;
    int           bad      = 0;
    int           cyc      = 0;
    int           accepted = 0;
    int           last_lat = -1;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_cout;

    always #5 clk = ~clk;

    brent_kung_adder_pipe #(
        .WIDTH (W),
        .STAGES(S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Sub      (Sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Sum      (Sum),
`ifdef BKA_PIPE_OVF_EN
        .Ovf      (Ovf),
`endif
        .Cout     (Cout)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   t;
        bx     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == bx[W-1]) && (t[W-1] != a[W-1]);
        e.cyc  = cyc;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score transfers, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_sum", 64'(Sum), 64'(held_sum));
                check("hold_cout", 64'(Cout), 64'(held_cout));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("sum", 64'(Sum), 64'(e.sum));
                    check("cout", 64'(Cout), 64'(e.cout));
`ifdef BKA_PIPE_OVF_EN
                    check("ovf", 64'(Ovf), 64'(e.ovf));
`endif
                    last_lat = cyc - e.cyc;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, Cin, Sub));
                accepted++;
            end
            stall_prev = out_valid && !out_ready;
            held_sum   = Sum;
            held_cout  = Cout;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub);
        A        = a;
        B        = b;
        Cin      = cin;
        Sub      = sub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int start;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        Sub       = 1'b0;

        repeat (3) step();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(Sum), 64'(0));
        check("rst_cout", 64'(Cout), 64'(0));
`ifdef BKA_PIPE_OVF_EN
        check("rst_ovf", 64'(Ovf), 64'(0));
`endif
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Carry wrap and latency from an empty pipe.
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        drain(20);
        check("lat_wrap", 64'(last_lat), 64'(S));

        // Subtract both ways, back to back.
        A = 32'd5; B = 32'd7; Cin = 1'b1; Sub = 1'b1; in_valid = 1'b1;
        step();
        A = 32'd7; B = 32'd5;
        step();
        in_valid = 1'b0;
        drain(20);

`ifdef BKA_PIPE_OVF_EN
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        send(32'h1, 32'h1, 1'b0, 1'b0);
        drain(20);
`endif

        // Random back-to-back stream with pseudo-random backpressure.
        start    = accepted;
        n        = 0;
        in_valid = 1'b1;
        while (accepted - start < 100 && n < 2000) begin
            A         = $urandom();
            B         = $urandom();
            Cin       = 1'($urandom_range(0, 1));
            Sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_count", 64'(accepted - start), 64'(100));
        drain(50);

        // Fill with the consumer stalled; in_ready must drop.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            A   = $urandom();
            B   = $urandom();
            Cin = 1'b0;
            Sub = 1'b0;
            step();
        end
        check("fill_out_valid", 64'(out_valid), 64'(1));
        check("fill_in_ready", 64'(in_ready), 64'(0));
        check("fill_depth", 64'(q.size()), 64'(S));

        // Reset mid-stream discards in-flight results.
        rst = 1'b1;
        step();
        step();
        q.delete();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_stale", 64'(out_valid), 64'(0));
        end

        send(32'd3, 32'd4, 1'b0, 1'b0);
        drain(20);
        check("lat_post_rst", 64'(last_lat), 64'(S));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
